// File: rtl/vga_pkg.sv
// Shared definitions for the framebuffer/VGA slice: read-owner encoding and a
// constant log2 helper used to size counters.
package vga_pkg;

  localparam logic OWN_DISP = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register of {valid, owner} tags that tracks outstanding RAM reads so
// the returning word can be steered to the requester that issued it.
import vga_pkg::*;

module rd_tag_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic owner_i,
  output logic valid_o,
  output logic owner_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] owner_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      owner_q[0] <= owner_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign owner_o = owner_q[DEPTH-1];

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display has priority, host is protected by
// a bounded-wait counter; RAM control is registered and read data is routed back.
import vga_pkg::*;

module fb_arbiter #(
  parameter int unsigned ADDR_BITS    = 19,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned RAM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                 clk_pll,
  input  logic                 rst,
  input  logic                 disp_req,
  input  logic [ADDR_BITS-1:0] disp_addr,
  output logic                 disp_gnt,
  output logic                 disp_rvalid,
  output logic [DATA_BITS-1:0] disp_rdata,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [DATA_BITS-1:0] host_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_wdata,
  input  logic [DATA_BITS-1:0] ram_rdata
);

  localparam int unsigned CW = clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]        starve_q, starve_d;
  logic                 ram_en_q, ram_we_q, ram_own_q;
  logic [ADDR_BITS-1:0] ram_addr_q;
  logic [DATA_BITS-1:0] ram_wdata_q;
  logic                 disp_rvalid_q, host_rvalid_q;
  logic [DATA_BITS-1:0] disp_rdata_q, host_rdata_q;
  logic                 tag_valid, tag_owner;

  // Grants are forced low during reset so no transfer can be accepted then.
  always_comb begin
    disp_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      if (disp_req && host_req) begin
        if (starve_q == LIMIT) host_gnt = 1'b1;
        else                   disp_gnt = 1'b1;
      end else if (disp_req) begin
        disp_gnt = 1'b1;
      end else if (host_req) begin
        host_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!host_req || host_gnt) starve_d = '0;
    else if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_pll) begin
    if (rst) begin
      starve_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_own_q   <= OWN_DISP;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      ram_en_q <= disp_gnt | host_gnt;
      ram_we_q <= host_gnt & host_we;
      if (host_gnt) begin
        ram_own_q   <= OWN_HOST;
        ram_addr_q  <= host_addr;
        ram_wdata_q <= host_wdata;
      end else if (disp_gnt) begin
        ram_own_q  <= OWN_DISP;
        ram_addr_q <= disp_addr;
      end
    end
  end

  rd_tag_pipe #(
    .DEPTH (RAM_LATENCY)
  ) u_tags (
    .clk_i   (clk_pll),
    .rst_i   (rst),
    .valid_i (ram_en_q & ~ram_we_q),
    .owner_i (ram_own_q),
    .valid_o (tag_valid),
    .owner_o (tag_owner)
  );

  always_ff @(posedge clk_pll) begin
    if (rst) begin
      disp_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
      host_rdata_q  <= '0;
    end else begin
      disp_rvalid_q <= tag_valid && (tag_owner == OWN_DISP);
      host_rvalid_q <= tag_valid && (tag_owner == OWN_HOST);
      if (tag_valid && (tag_owner == OWN_DISP)) disp_rdata_q <= ram_rdata;
      if (tag_valid && (tag_owner == OWN_HOST)) host_rdata_q <= ram_rdata;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign disp_rdata  = disp_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: vector table for display/host basics, plus
// sequences for starvation/interleave, mid-flight reset and latency sweep.
module tb_fb_arbiter;
  localparam int AB = 19;
  localparam int DB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, disp_req, host_req, host_we, preload;
  logic [AB-1:0] disp_addr, host_addr;
  logic [DB-1:0] host_wdata;

  logic          disp_gnt, disp_rvalid, host_gnt, host_rvalid, ram_en, ram_we;
  logic [DB-1:0] disp_rdata, host_rdata, ram_wdata, m1;
  logic [AB-1:0] ram_addr;

  logic          s2_dg, s2_drv, s2_hg, s2_hrv, s2_en, s2_we;
  logic [DB-1:0] s2_drd, s2_hrd, s2_wd;
  logic [AB-1:0] s2_addr;
  logic          s4_dg, s4_drv, s4_hg, s4_hrv, s4_en, s4_we;
  logic [DB-1:0] s4_drd, s4_hrd, s4_wd;
  logic [AB-1:0] s4_addr;
  logic [DB-1:0] m2 [2];
  logic [DB-1:0] m4 [4];

  fb_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .RAM_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk_pll(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(m1));

  fb_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .RAM_LATENCY(2), .STARVE_LIMIT(4)) dut_l2 (
    .clk_pll(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(s2_dg),
    .disp_rvalid(s2_drv), .disp_rdata(s2_drd),
    .host_req(1'b0), .host_we(1'b0), .host_addr('0), .host_wdata('0),
    .host_gnt(s2_hg), .host_rvalid(s2_hrv), .host_rdata(s2_hrd),
    .ram_en(s2_en), .ram_we(s2_we), .ram_addr(s2_addr), .ram_wdata(s2_wd),
    .ram_rdata(m2[1]));

  fb_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .RAM_LATENCY(4), .STARVE_LIMIT(4)) dut_l4 (
    .clk_pll(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(s4_dg),
    .disp_rvalid(s4_drv), .disp_rdata(s4_drd),
    .host_req(1'b0), .host_we(1'b0), .host_addr('0), .host_wdata('0),
    .host_gnt(s4_hg), .host_rvalid(s4_hrv), .host_rdata(s4_hrd),
    .ram_en(s4_en), .ram_we(s4_we), .ram_addr(s4_addr), .ram_wdata(s4_wd),
    .ram_rdata(m4[3]));

  // RAM models: mem[a] = a after preload; read pipes of depth 1, 2 and 4.
  logic [DB-1:0] mem [0:511];
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 512; i++) mem[i] <= DB'(i);
    else if (ram_en && ram_we) mem[ram_addr[8:0]] <= ram_wdata;
  end
  always @(posedge clk) begin
    m1    <= mem[ram_addr[8:0]];
    m2[0] <= mem[s2_addr[8:0]];
    m2[1] <= m2[0];
    m4[0] <= mem[s4_addr[8:0]];
    for (int i = 1; i < 4; i++) m4[i] <= m4[i-1];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic dreq; logic [AB-1:0] daddr;
    logic hreq; logic hwe; logic [AB-1:0] haddr; logic [DB-1:0] hwd;
    logic e_dg; logic e_hg;
    logic e_drv; logic [DB-1:0] e_drd;
    logic e_hrv; logic [DB-1:0] e_hrd;
    logic e_en; logic e_we; logic [AB-1:0] e_addr; logic [DB-1:0] e_wd;
  } vec_t;

  function automatic vec_t mk(
    input logic dreq, input logic [AB-1:0] daddr,
    input logic hreq, input logic hwe, input logic [AB-1:0] haddr, input logic [DB-1:0] hwd,
    input logic e_dg, input logic e_hg,
    input logic e_drv, input logic [DB-1:0] e_drd,
    input logic e_hrv, input logic [DB-1:0] e_hrd,
    input logic e_en, input logic e_we, input logic [AB-1:0] e_addr, input logic [DB-1:0] e_wd);
    vec_t v;
    v.dreq = dreq; v.daddr = daddr; v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
    v.e_dg = e_dg; v.e_hg = e_hg; v.e_drv = e_drv; v.e_drd = e_drd;
    v.e_hrv = e_hrv; v.e_hrd = e_hrd; v.e_en = e_en; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic drive(input logic r, input logic dq, input logic [AB-1:0] da,
                       input logic hq, input logic hw, input logic [AB-1:0] ha,
                       input logic [DB-1:0] hd);
    @(posedge clk); #1;
    rst = r; disp_req = dq; disp_addr = da;
    host_req = hq; host_we = hw; host_addr = ha; host_wdata = hd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dgnt"}, disp_gnt, 0);
    chk({tag, "_hgnt"}, host_gnt, 0);
    chk({tag, "_drv"},  disp_rvalid, 0);
    chk({tag, "_hrv"},  host_rvalid, 0);
    chk({tag, "_drd"},  disp_rdata, 0);
    chk({tag, "_hrd"},  host_rdata, 0);
    chk({tag, "_en"},   ram_en, 0);
    chk({tag, "_we"},   ram_we, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wd"},   ram_wdata, 0);
  endtask

  typedef struct { int cyc; logic [DB-1:0] d; } ex_t;
  vec_t vecs[$];
  ex_t  qd[$];
  ex_t  qh[$];
  logic ed, eh, xv;
  int   da, ha;

  initial begin
    rst = 1'b1; preload = 1'b1;
    disp_req = 1'b0; disp_addr = '0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk_all_zero("rst0");

    // Display-only reads 0..7, then host write/read of 0x100.
    for (int c = 0; c < 8; c++)
      vecs.push_back(mk(1, AB'(c), 0, 0, '0, '0, 1, 0, (c >= 3), DB'(c - 3), 0, '0,
                        (c >= 1), 0, AB'(c - 1), '0));
    vecs.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0, 1, 16'd5, 0, '0, 1, 0, 19'd7, '0));
    vecs.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0, 1, 16'd6, 0, '0, 0, 0, '0, '0));
    vecs.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0, 1, 16'd7, 0, '0, 0, 0, '0, '0));
    vecs.push_back(mk(0, '0, 1, 1, 19'h100, 16'hBEEF, 0, 1, 0, '0, 0, '0, 0, 0, '0, '0));
    vecs.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0, 0, '0, 0, '0, 1, 1, 19'h100, 16'hBEEF));
    vecs.push_back(mk(0, '0, 1, 0, 19'h100, '0, 0, 1, 0, '0, 0, '0, 0, 0, '0, '0));
    vecs.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0, 0, '0, 0, '0, 1, 0, 19'h100, '0));
    vecs.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0, 0, '0, 0, '0, 0, 0, '0, '0));
    vecs.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0, 0, '0, 1, 16'hBEEF, 0, 0, '0, '0));

    foreach (vecs[i]) begin
      drive(0, vecs[i].dreq, vecs[i].daddr, vecs[i].hreq, vecs[i].hwe,
            vecs[i].haddr, vecs[i].hwd);
      @(negedge clk);
      chk($sformatf("v%0d_dgnt", i), disp_gnt, vecs[i].e_dg);
      chk($sformatf("v%0d_hgnt", i), host_gnt, vecs[i].e_hg);
      chk($sformatf("v%0d_drv", i), disp_rvalid, vecs[i].e_drv);
      if (vecs[i].e_drv) chk($sformatf("v%0d_drd", i), disp_rdata, vecs[i].e_drd);
      chk($sformatf("v%0d_hrv", i), host_rvalid, vecs[i].e_hrv);
      if (vecs[i].e_hrv) chk($sformatf("v%0d_hrd", i), host_rdata, vecs[i].e_hrd);
      chk($sformatf("v%0d_en", i), ram_en, vecs[i].e_en);
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d_we", i), ram_we, vecs[i].e_we);
        chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].e_addr);
        if (vecs[i].e_we) chk($sformatf("v%0d_wd", i), ram_wdata, vecs[i].e_wd);
      end
      // Latency sweep: same display traffic, rvalid at grant + 2 + L.
      if (i < 16) begin
        xv = (i >= 4 && i <= 11);
        chk($sformatf("l2_%0d_rv", i), s2_drv, xv);
        if (xv) chk($sformatf("l2_%0d_rd", i), s2_drd, DB'(i - 4));
        xv = (i >= 6 && i <= 13);
        chk($sformatf("l4_%0d_rv", i), s4_drv, xv);
        if (xv) chk($sformatf("l4_%0d_rd", i), s4_drd, DB'(i - 6));
      end
    end

    // Starvation and interleaved reads: host forced every 5th cycle.
    da = 32; ha = 48;
    for (int k = 0; k < 20; k++) begin
      drive(0, (k < 15), AB'(da), (k < 15), 0, AB'(ha), '0);
      @(negedge clk);
      eh = (k < 15) && (k % 5 == 4);
      ed = (k < 15) && !eh;
      chk($sformatf("st%0d_dgnt", k), disp_gnt, ed);
      chk($sformatf("st%0d_hgnt", k), host_gnt, eh);
      if (k == 2) chk("st_cnt2", dut.starve_q, 2);
      if (k == 4) chk("st_cnt4", dut.starve_q, 4);
      if (k == 5) chk("st_cnt5", dut.starve_q, 0);
      xv = (qd.size() > 0) && (qd[0].cyc == k);
      chk($sformatf("st%0d_drv", k), disp_rvalid, xv);
      if (xv) begin
        chk($sformatf("st%0d_drd", k), disp_rdata, qd[0].d);
        void'(qd.pop_front());
      end
      xv = (qh.size() > 0) && (qh[0].cyc == k);
      chk($sformatf("st%0d_hrv", k), host_rvalid, xv);
      if (xv) begin
        chk($sformatf("st%0d_hrd", k), host_rdata, qh[0].d);
        void'(qh.pop_front());
      end
      if (ed) begin qd.push_back('{k + 3, DB'(da)}); da++; end
      if (eh) begin qh.push_back('{k + 3, DB'(ha)}); ha++; end
    end
    chk("st_qd_empty", qd.size(), 0);
    chk("st_qh_empty", qh.size(), 0);

    // Reset with two display reads in flight; host request ignored under reset.
    drive(0, 1, 19'd5, 0, 0, '0, '0);
    @(negedge clk); chk("r0_dgnt", disp_gnt, 1);
    drive(0, 1, 19'd6, 0, 0, '0, '0);
    @(negedge clk); chk("r1_dgnt", disp_gnt, 1); chk("r1_en", ram_en, 1);
    drive(1, 1, 19'd7, 1, 0, 19'd9, '0);
    @(negedge clk); chk("r2_dgnt", disp_gnt, 0); chk("r2_hgnt", host_gnt, 0);
    drive(1, 1, 19'd7, 1, 0, 19'd9, '0);
    @(negedge clk); chk_all_zero("r3");
    drive(1, 1, 19'd7, 1, 0, 19'd9, '0);
    @(negedge clk); chk_all_zero("r4");
    drive(0, 1, 19'd7, 0, 0, '0, '0);
    @(negedge clk);
    chk("r5_dgnt", disp_gnt, 1); chk("r5_en", ram_en, 0); chk("r5_drv", disp_rvalid, 0);
    drive(0, 0, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("r6_en", ram_en, 1); chk("r6_addr", ram_addr, 7); chk("r6_drv", disp_rvalid, 0);
    drive(0, 0, '0, 0, 0, '0, '0);
    @(negedge clk); chk("r7_drv", disp_rvalid, 0); chk("r7_hrv", host_rvalid, 0);
    drive(0, 0, '0, 0, 0, '0, '0);
    @(negedge clk); chk("r8_drv", disp_rvalid, 1); chk("r8_drd", disp_rdata, 7);
    drive(0, 0, '0, 0, 0, '0, '0);
    @(negedge clk); chk("r9_drv", disp_rvalid, 0); chk("r9_hrv", host_rvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
